fractal_decoder: RTL and testbench

- Decode side of the fractal coefficient path: consumes one 128-bit fractal coefficient word (four x/y point pairs) and reconstructs a 256-bit pixel block (32 x 8-bit pixels, 8 wide x 4 high).
- Reconstruction is chaos-game style. Each point is iterated through a fixed Q1.15 affine contraction, and every landing pixel is incremented with saturation.
- Supports the quantum-mode unmask: XOR of coefficient fields with quantum_state.
- Sits downstream of the encoder output / HBM readback, with valid/ready on both sides.

---
 rtl/fractal_decoder.sv | 138 +++++++++++++
 tb/tb_fractal_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_decoder.sv
// rtl/fractal_decoder.sv - chaos-game fractal coefficient decoder producing an 8x4 pixel block
module fractal_decoder (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] coeff_in,
    input  logic         coeff_valid,
    output logic         coeff_ready,
    input  logic [31:0]  config_reg,
    input  logic [63:0]  quantum_state,
    output logic [255:0] pixel_block_out,
    output logic         pixel_valid,
    input  logic         pixel_ready,
    output logic         busy
);

    localparam logic signed [32:0] A33 = 33'sh0_0000_6CCC;
    localparam logic signed [32:0] B33 = 33'sh0_0000_051F;
    localparam logic signed [32:0] C33 = -33'sd1311;
    localparam logic signed [32:0] D33 = 33'sh0_0000_6CCC;
    localparam logic [15:0]        E   = 16'h0000;
    localparam logic [15:0]        F   = 16'h1999;
    localparam logic [7:0]         INC = 8'h40;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0][15:0]     px_q, px_d;
    logic [3:0][15:0]     py_q, py_d;
    logic [1:0]           pt_q, pt_d;
    logic [7:0]           iter_q, iter_d;
    logic [7:0]           n_q, n_d;
    logic [255:0]         canvas_q, canvas_d;
    logic [255:0]         block_q, block_d;

    logic signed [32:0]   xe, ye, sx, sy;
    logic [15:0]          x_new, y_new;
    logic [4:0]           pix;
    logic [7:0]           old_pix;
    logic [8:0]           sum9;
    logic [7:0]           sat_pix;
    logic [15:0]          xmask, ymask;
    logic                 unused_bits;

    assign unused_bits = ^{config_reg[31:26], config_reg[24:8],
                           quantum_state[63:48], quantum_state[15:0]};

    assign coeff_ready     = (state_q == S_IDLE) && !rst;
    assign pixel_valid     = (state_q == S_DONE);
    assign busy            = (state_q != S_IDLE);
    assign pixel_block_out = block_q;

    // Affine contraction of the current point and saturating canvas increment at its landing pixel
    always_comb begin
        xe      = {{17{px_q[pt_q][15]}}, px_q[pt_q]};
        ye      = {{17{py_q[pt_q][15]}}, py_q[pt_q]};
        sx      = xe * A33 + ye * B33;
        sy      = xe * C33 + ye * D33;
        x_new   = 16'(sx >>> 15) + E;
        y_new   = 16'(sy >>> 15) + F;
        pix     = {y_new[14:13], x_new[14:12]};
        old_pix = canvas_q[{pix, 3'b000} +: 8];
        sum9    = {1'b0, old_pix} + {1'b0, INC};
        sat_pix = sum9[8] ? 8'hFF : sum9[7:0];
    end

    // Next-state: accept and unmask in IDLE, walk points in ITER, hold result in DONE
    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        pt_d     = pt_q;
        iter_d   = iter_q;
        n_d      = n_q;
        canvas_d = canvas_q;
        block_d  = block_q;
        xmask    = config_reg[25] ? quantum_state[31:16] : 16'h0000;
        ymask    = config_reg[25] ? quantum_state[47:32] : 16'h0000;
        case (state_q)
            S_IDLE: begin
                if (coeff_valid && coeff_ready) begin
                    for (int p = 0; p < 4; p++) begin
                        px_d[p] = coeff_in[127 - 32*p -: 16] ^ xmask;
                        py_d[p] = coeff_in[111 - 32*p -: 16] ^ ymask;
                    end
                    n_d      = (config_reg[7:0] == 8'd0) ? 8'd1 : config_reg[7:0];
                    pt_d     = 2'd0;
                    iter_d   = 8'd0;
                    canvas_d = '0;
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                px_d[pt_q] = x_new;
                py_d[pt_q] = y_new;
                canvas_d[{pix, 3'b000} +: 8] = sat_pix;
                pt_d = pt_q + 2'd1;
                if (pt_q == 2'd3) begin
                    if (iter_q == n_q - 8'd1) begin
                        block_d = canvas_d;
                        state_d = S_DONE;
                    end else begin
                        iter_d = iter_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (pixel_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any block in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            px_q     <= '0;
            py_q     <= '0;
            pt_q     <= 2'd0;
            iter_q   <= 8'd0;
            n_q      <= 8'd0;
            canvas_q <= '0;
            block_q  <= '0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            pt_q     <= pt_d;
            iter_q   <= iter_d;
            n_q      <= n_d;
            canvas_q <= canvas_d;
            block_q  <= block_d;
        end
    end

endmodule

// File: tb/tb_fractal_decoder.sv
// tb/tb_fractal_decoder.sv - scoreboard bench for fractal_decoder with randomized decodes
module tb_fractal_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] coeff_in;
    logic         coeff_valid;
    logic         coeff_ready;
    logic [31:0]  config_reg;
    logic [63:0]  quantum_state;
    logic [255:0] pixel_block_out;
    logic         pixel_valid;
    logic         pixel_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic [255:0] sb[$];
    logic [255:0] mon_exp;

    localparam longint KA = 27852;
    localparam longint KB = 1311;
    localparam longint KC = -1311;
    localparam longint KD = 27852;
    localparam longint KE = 0;
    localparam longint KF = 6553;

    fractal_decoder dut (
        .clk(clk), .rst(rst),
        .coeff_in(coeff_in), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .config_reg(config_reg), .quantum_state(quantum_state),
        .pixel_block_out(pixel_block_out), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic longint wrap16(input longint v);
        return ((v & 64'hFFFF) ^ 64'h8000) - 64'h8000;
    endfunction

    // Reference: count landings per pixel, then each pixel is min(64*hits, 255)
    function automatic logic [255:0] model(input logic [127:0] c, input logic [31:0] cfg,
                                           input logic [63:0] qs);
        longint x[4], y[4];
        longint nx, ny;
        int hits[32];
        int n, idx, v;
        logic [15:0] xr, yr;
        logic [255:0] r;
        for (int p = 0; p < 4; p++) begin
            xr = c[127 - 32*p -: 16];
            yr = c[111 - 32*p -: 16];
            if (cfg[25]) begin
                xr = xr ^ qs[31:16];
                yr = yr ^ qs[47:32];
            end
            x[p] = longint'($signed(xr));
            y[p] = longint'($signed(yr));
        end
        for (int i = 0; i < 32; i++) hits[i] = 0;
        n = (cfg[7:0] == 8'd0) ? 1 : int'(cfg[7:0]);
        for (int it = 0; it < n; it++) begin
            for (int p = 0; p < 4; p++) begin
                nx = wrap16(((KA * x[p] + KB * y[p]) >>> 15) + KE);
                ny = wrap16(((KC * x[p] + KD * y[p]) >>> 15) + KF);
                x[p] = nx;
                y[p] = ny;
                idx = int'(((ny >> 13) & 3) * 8 + ((nx >> 12) & 7));
                hits[idx]++;
            end
        end
        r = '0;
        for (int i = 0; i < 32; i++) begin
            v = hits[i] * 64;
            r[i*8 +: 8] = (v > 255) ? 8'hFF : v[7:0];
        end
        return r;
    endfunction

    // Monitor: every output handshake pops and compares one expected block
    always @(negedge clk) begin
        if (!rst && pixel_valid && pixel_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL block_unexpected actual=%h required=none", pixel_block_out);
            end else begin
                mon_exp = sb.pop_front();
                chk("block", pixel_block_out, mon_exp);
            end
        end
    end

    task automatic decode(input logic [127:0] c, input logic [31:0] cfg, input logic [63:0] qs,
                          input logic [255:0] exp, input int bp);
        int n, k;
        logic [255:0] held;
        n = (cfg[7:0] == 8'd0) ? 1 : int'(cfg[7:0]);
        @(posedge clk); #1;
        coeff_in = c; config_reg = cfg; quantum_state = qs; coeff_valid = 1'b1; pixel_ready = 1'b0;
        @(negedge clk);
        chk("ready_idle", coeff_ready, 1);
        sb.push_back(exp);
        @(posedge clk); #1;
        coeff_valid = 1'b0;
        config_reg = $urandom;
        quantum_state = {$urandom, $urandom};
        coeff_in = rand128();
        k = 1;
        @(negedge clk);
        while (!pixel_valid && k < 1100) begin
            chk("ready_low_iter", coeff_ready, 0);
            chk("busy_iter", busy, 1);
            coeff_valid = 1'($urandom);
            coeff_in = rand128();
            @(negedge clk);
            k++;
        end
        chk("latency", k, 4*n + 1);
        held = pixel_block_out;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            coeff_valid = 1'($urandom);
            coeff_in = rand128();
            @(negedge clk);
            chk("valid_hold", pixel_valid, 1);
            chk("ready_low_done", coeff_ready, 0);
            chk("busy_done", busy, 1);
            chk("block_stable", pixel_block_out, held);
        end
        @(posedge clk); #1;
        pixel_ready = 1'b1;
        coeff_valid = 1'b0;
        @(posedge clk); #1;
        pixel_ready = 1'b0;
        @(negedge clk);
        chk("valid_drop", pixel_valid, 0);
        chk("ready_after_done", coeff_ready, 1);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [255:0] e;
        logic [31:0]  cfg;
        rst = 1'b1; coeff_in = '0; coeff_valid = 1'b0; config_reg = '0;
        quantum_state = '0; pixel_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", coeff_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", coeff_ready, 1);
        chk("reset_valid", pixel_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_block", pixel_block_out, 0);

        decode(128'h0, 32'h0, 64'h0, 256'hFF, 0);
        e = (256'h40 << 128) | 256'hC0;
        decode({16'h0000, 16'h4000, 96'h0}, 32'd1, 64'h0, e, 2);
        decode(128'h0, 32'h0200_0000, 64'h0000_4000_0000_0000, 256'hFF << 128, 1);
        decode(128'h0, 32'h0000_0000, 64'h0000_4000_0000_0000, 256'hFF, 0);
        coeff_in = rand128();
        decode(coeff_in, 32'd3, 64'h0, model(coeff_in, 32'd3, 64'h0), 10);

        // Reset at T+3 of an N=2 decode
        @(posedge clk); #1;
        coeff_in = rand128(); config_reg = 32'd2; coeff_valid = 1'b1;
        @(posedge clk); #1;
        coeff_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_mid_reset", coeff_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_valid", pixel_valid, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_block", pixel_block_out, 0);
        chk("mid_reset_ready", coeff_ready, 1);
        decode(128'h0, 32'h0, 64'h0, 256'hFF, 0);

        for (int t = 0; t < 16; t++) begin
            cfg = $urandom;
            cfg[7:0] = 8'($urandom_range(0, 5));
            coeff_in = rand128();
            quantum_state = {$urandom, $urandom};
            decode(coeff_in, cfg, quantum_state, model(coeff_in, cfg, quantum_state),
                   int'($urandom_range(0, 3)));
        end

        cfg = $urandom;
        cfg[7:0] = 8'd255;
        coeff_in = rand128();
        quantum_state = {$urandom, $urandom};
        decode(coeff_in, cfg, quantum_state, model(coeff_in, cfg, quantum_state), 1);

        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
